// File: rtl/sram_fifo_arbiter.sv
// Round-robin scheduler for the four SRAM FIFO access channels.
// Issues one controller strobe at a time, acks on the matching hint, and aborts hung accesses.
module sram_fifo_arbiter #(
    parameter int TIMEOUT = 24,
    parameter int TO_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       fifo_i_full,
    input  logic       fifo_o_empty,
    input  logic       fifo_o_full,
    input  logic       fifo_i_empty,
    input  logic       slave_hint,
    input  logic       master_hint,
    input  logic       err_clr,
    output logic [3:0] ctrl_op,
    output logic [3:0] ack,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [TO_W-1:0] wd_r, wd_s;
    logic [1:0]      last_r, last_s;
    logic [1:0]      grant_s;
    logic [3:0]      ctrl_s, ack_s, elig_s;
    logic            busy_s, err_s, match_s;
    logic [2:0]      pick_s;

    // Returns {valid, index} of the first eligible channel after 'last'.
    function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!res[2] && elig[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Eligibility, round-robin choice and hint matching for the current grant.
    always_comb begin
        elig_s  = req & ~{fifo_i_empty, fifo_o_full, fifo_o_empty, fifo_i_full};
        pick_s  = rr_pick(elig_s, last_r);
        match_s = grant_id[1] ? master_hint : slave_hint;
    end

    // Next-state and next-output logic of the scheduler FSM.
    always_comb begin
        state_s = state_r;
        wd_s    = wd_r;
        last_s  = last_r;
        grant_s = grant_id;
        ctrl_s  = ctrl_op;
        ack_s   = 4'b0000;
        err_s   = timeout_err;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[2]) begin
                    grant_s = pick_s[1:0];
                    ctrl_s  = 4'b0001 << pick_s[1:0];
                    wd_s    = '0;
                    state_s = ST_ISSUE;
                end else begin
                    ctrl_s  = 4'b0000;
                end
            end
            ST_ISSUE: begin
                if (match_s) begin
                    ctrl_s  = 4'b0000;
                    ack_s   = 4'b0001 << grant_id;
                    last_s  = grant_id;
                    state_s = ST_RECOVER;
                end else if (wd_r == TO_W'(TIMEOUT - 1)) begin
                    ctrl_s  = 4'b0000;
                    err_s   = 1'b1;
                    last_s  = grant_id;
                    state_s = ST_RECOVER;
                end else begin
                    wd_s    = wd_r + {{(TO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RECOVER: begin
                ctrl_s  = 4'b0000;
                state_s = ST_IDLE;
            end
            default: begin
                ctrl_s  = 4'b0000;
                state_s = ST_IDLE;
            end
        endcase
        // A clear request wins over an abort in the same cycle.
        if (err_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_s;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State, watchdog and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wd_r        <= '0;
            last_r      <= 2'd3;
            grant_id    <= 2'd0;
            ctrl_op     <= 4'b0000;
            ack         <= 4'b0000;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_r     <= state_s;
            wd_r        <= wd_s;
            last_r      <= last_s;
            grant_id    <= grant_s;
            ctrl_op     <= ctrl_s;
            ack         <= ack_s;
            busy        <= busy_s;
            timeout_err <= err_s;
        end
    end

endmodule

// File: tb/tb_sram_fifo_arbiter.sv
// Directed bench for sram_fifo_arbiter: grant order, flag gating, hint matching,
// watchdog abort and asynchronous reset.
module tb_sram_fifo_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       fifo_i_full, fifo_o_empty, fifo_o_full, fifo_i_empty;
    logic       slave_hint, master_hint, err_clr;
    logic [3:0] ctrl_op, ack;
    logic [1:0] grant_id;
    logic       busy, timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_fifo_arbiter #(.TIMEOUT(24), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .req(req),
        .fifo_i_full(fifo_i_full), .fifo_o_empty(fifo_o_empty),
        .fifo_o_full(fifo_o_full), .fifo_i_empty(fifo_i_empty),
        .slave_hint(slave_hint), .master_hint(master_hint), .err_clr(err_clr),
        .ctrl_op(ctrl_op), .ack(ack), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances until a strobe appears, bounded to 20 cycles.
    task automatic wait_strobe();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (ctrl_op == 4'b0000 && n < 20);
        check_eq("strobe_seen", 32'(ctrl_op != 4'b0000), 32'd1);
    endtask

    // One prompt access on channel ch; optionally drops that request after its ack.
    task automatic serve(input int ch, input bit drop);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        wait_strobe();
        check_eq($sformatf("grant_op%0d", ch), 32'(ctrl_op), 32'(oh));
        check_eq($sformatf("grant_id%0d", ch), 32'(grant_id), 32'(ch));
        check_eq($sformatf("no_ack_issue%0d", ch), 32'(ack), 32'd0);
        if (ch < 2) slave_hint = 1'b1;
        else        master_hint = 1'b1;
        tick();
        check_eq($sformatf("ack%0d", ch), 32'(ack), 32'(oh));
        check_eq($sformatf("op_drop%0d", ch), 32'(ctrl_op), 32'd0);
        check_eq($sformatf("busy_rec%0d", ch), 32'(busy), 32'd1);
        slave_hint  = 1'b0;
        master_hint = 1'b0;
        if (drop) req[ch] = 1'b0;
    endtask

    initial begin
        int         cnt;
        logic [3:0] acks;
        rst = 1'b1; req = 4'b0000;
        fifo_i_full = 1'b0; fifo_o_empty = 1'b0; fifo_o_full = 1'b0; fifo_i_empty = 1'b0;
        slave_hint = 1'b0; master_hint = 1'b0; err_clr = 1'b0;
        tick(); tick();
        check_eq("rst_op",    32'(ctrl_op),     32'd0);
        check_eq("rst_ack",   32'(ack),         32'd0);
        check_eq("rst_grant", 32'(grant_id),    32'd0);
        check_eq("rst_busy",  32'(busy),        32'd0);
        check_eq("rst_err",   32'(timeout_err), 32'd0);
        rst = 1'b0;

        // 1: single slave write, hint three cycles after the strobe
        req = 4'b0001;
        tick();
        check_eq("t1_op_c1", 32'(ctrl_op), 32'h1);
        check_eq("t1_busy",  32'(busy),    32'd1);
        tick();
        check_eq("t1_op_c2", 32'(ctrl_op), 32'h1);
        tick();
        check_eq("t1_op_c3", 32'(ctrl_op), 32'h1);
        slave_hint = 1'b1;
        tick();
        check_eq("t1_op_off", 32'(ctrl_op), 32'h0);
        check_eq("t1_ack",    32'(ack),     32'h1);
        check_eq("t1_busy_r", 32'(busy),    32'd1);
        slave_hint = 1'b0; req = 4'b0000;
        tick();
        check_eq("t1_ack_off", 32'(ack),  32'h0);
        check_eq("t1_idle",    32'(busy), 32'd0);

        // 2: all requests held, round-robin from reset
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        serve(0, 1'b0); serve(1, 1'b0); serve(2, 1'b0); serve(3, 1'b0); serve(0, 1'b0);
        req = 4'b0000;
        tick(); tick();

        // 3: output FIFO empty blocks channel 1 until cleared
        req = 4'b0110; fifo_o_empty = 1'b1;
        serve(2, 1'b1);
        fifo_o_empty = 1'b0;
        serve(1, 1'b1);
        tick(); tick();

        // 4: master read never completes; watchdog aborts after 24 strobe cycles
        req = 4'b1000;
        wait_strobe();
        check_eq("t4_op", 32'(ctrl_op), 32'h8);
        cnt = 1; acks = 4'b0000;
        while (ctrl_op != 4'b0000 && cnt < 40) begin
            tick();
            acks = acks | ack;
            if (ctrl_op != 4'b0000) cnt++;
        end
        check_eq("t4_len",  32'(cnt),         32'd24);
        check_eq("t4_noack",32'(acks),        32'd0);
        check_eq("t4_err",  32'(timeout_err), 32'd1);
        req = 4'b0000;
        tick();
        check_eq("t4_idle",   32'(busy),        32'd0);
        check_eq("t4_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t4_clr", 32'(timeout_err), 32'd0);

        // 6: a master hint during a slave access is ignored
        req = 4'b0001;
        wait_strobe();
        check_eq("t6_op", 32'(ctrl_op), 32'h1);
        master_hint = 1'b1;
        tick();
        master_hint = 1'b0;
        check_eq("t6_hold",  32'(ctrl_op), 32'h1);
        check_eq("t6_noack", 32'(ack),     32'h0);
        slave_hint = 1'b1;
        tick();
        slave_hint = 1'b0;
        check_eq("t6_ack", 32'(ack),     32'h1);
        check_eq("t6_off", 32'(ctrl_op), 32'h0);
        req = 4'b0000;
        tick(); tick();

        // 5: reset in the middle of a master write access
        req = 4'b0100;
        wait_strobe();
        check_eq("t5_op",    32'(ctrl_op),  32'h4);
        check_eq("t5_grant", 32'(grant_id), 32'd2);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_op",   32'(ctrl_op), 32'h0);
        check_eq("t5_rst_ack",  32'(ack),     32'h0);
        check_eq("t5_rst_busy", 32'(busy),    32'd0);
        tick();
        rst = 1'b0;
        req = 4'b0101;
        serve(0, 1'b1);
        serve(2, 1'b1);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
